// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU control sequencer.
package cpu_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned TCNT_W  = 8;

    localparam int unsigned OP_MSB  = 7;
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned RS_MSB  = 5;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned RT_MSB  = 3;
    localparam int unsigned RT_LSB  = 2;
    localparam int unsigned RD_MSB  = 1;
    localparam int unsigned RD_LSB  = 0;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    typedef struct packed {
        logic instr_req;
        logic regdst;
        logic regwrite;
        logic alusrc;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic pc_en;
        logic pc_jump;
    } ctrl_t;

    function automatic logic [1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/cpu_control_decode.sv
// Combinational strobe decode from sequencer state and latched opcode.
import cpu_pkg::*;

module cpu_control_decode (
    input  state_t     state,
    input  logic [1:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: ctrl.instr_req = 1'b1;
            EXEC: begin
                ctrl.alusrc  = (opcode == OP_LW) || (opcode == OP_SW);
                ctrl.pc_en   = (opcode == OP_JMP);
                ctrl.pc_jump = (opcode == OP_JMP);
            end
            MEM: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = (opcode == OP_LW);
                ctrl.memwrite = (opcode == OP_SW);
                // SW retires in MEM on the completing cycle
                ctrl.pc_en    = (opcode == OP_SW) && mem_ready;
            end
            WB: begin
                ctrl.regwrite = 1'b1;
                ctrl.pc_en    = 1'b1;
                ctrl.regdst   = (opcode == OP_ADD);
                ctrl.memtoreg = (opcode == OP_LW);
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 8-bit CPU.
// Optional single-step start input enabled by CPU_CONTROL_SINGLE_STEP_EN.
import cpu_pkg::*;

module cpu_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic               mem_ready,
`ifdef CPU_CONTROL_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               instr_req,
    output logic [INSTR_W-1:0] ir,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrc,
    output logic               memread,
    output logic               memwrite,
    output logic               memtoreg,
    output logic               pc_en,
    output logic               pc_jump,
    output logic               busy,
    output logic               err,
    output logic [COUNT_W-1:0] instr_count
);

    state_t             state, state_nx;
    logic [INSTR_W-1:0] ir_q, ir_nx;
    logic               err_q, err_nx;
    logic [TCNT_W-1:0]  tcount, tcount_nx;
    logic [COUNT_W-1:0] count_q, count_nx;
    logic               cont_c;
    ctrl_t              ctrl;

`ifdef CPU_CONTROL_SINGLE_STEP_EN
    logic step_q;
    logic single_q, single_nx;
`endif

    cpu_control_decode u_decode (
        .state     (state),
        .opcode    (opcode_of(ir_q)),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // State and datapath-visible registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            ir_q    <= '0;
            err_q   <= 1'b0;
            tcount  <= '0;
            count_q <= '0;
        end else begin
            state   <= state_nx;
            ir_q    <= ir_nx;
            err_q   <= err_nx;
            tcount  <= tcount_nx;
            count_q <= count_nx;
        end
    end

`ifdef CPU_CONTROL_SINGLE_STEP_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            step_q   <= 1'b0;
            single_q <= 1'b0;
        end else begin
            step_q   <= step;
            single_q <= single_nx;
        end
    end

    assign cont_c = run && !single_q;
`else
    assign cont_c = run;
`endif

    // Next-state, timeout and retire bookkeeping
    always_comb begin
        state_nx  = state;
        ir_nx     = ir_q;
        err_nx    = err_q;
        tcount_nx = tcount;
        count_nx  = count_q;
`ifdef CPU_CONTROL_SINGLE_STEP_EN
        single_nx = single_q;
`endif
        case (state)
            IDLE: begin
                if (!err_q && run) begin
                    state_nx = FETCH;
`ifdef CPU_CONTROL_SINGLE_STEP_EN
                end else if (!err_q && step && !step_q) begin
                    state_nx  = FETCH;
                    single_nx = 1'b1;
`endif
                end
            end
            FETCH: begin
                if (instr_valid) begin
                    ir_nx    = instr;
                    state_nx = DECODE;
                end
            end
            DECODE: state_nx = EXEC;
            EXEC: begin
                if (opcode_of(ir_q) == OP_ADD) begin
                    state_nx = WB;
                end else if (opcode_of(ir_q) != OP_JMP) begin
                    tcount_nx = '0;
                    state_nx  = MEM;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    if (opcode_of(ir_q) == OP_LW) state_nx = WB;
                end else begin
                    tcount_nx = tcount + TCNT_W'(1);
                    if (tcount == TCNT_W'(MEM_TIMEOUT - 1)) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
`ifdef CPU_CONTROL_SINGLE_STEP_EN
                        single_nx = 1'b0;
`endif
                    end
                end
            end
            WB: state_nx = WB;
            default: state_nx = IDLE;
        endcase

        // pc_en marks exactly one retire cycle per instruction
        if (ctrl.pc_en) begin
            count_nx = count_q + COUNT_W'(1);
            state_nx = cont_c ? FETCH : IDLE;
`ifdef CPU_CONTROL_SINGLE_STEP_EN
            single_nx = 1'b0;
`endif
        end
    end

    assign instr_req   = ctrl.instr_req;
    assign regdst      = ctrl.regdst;
    assign regwrite    = ctrl.regwrite;
    assign alusrc      = ctrl.alusrc;
    assign memread     = ctrl.memread;
    assign memwrite    = ctrl.memwrite;
    assign memtoreg    = ctrl.memtoreg;
    assign pc_en       = ctrl.pc_en;
    assign pc_jump     = ctrl.pc_jump;
    assign ir          = ir_q;
    assign busy        = (state != IDLE);
    assign err         = err_q;
    assign instr_count = count_q;

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multi-cycle control sequencer for the 8-bit, 4-register CPU datapath.
- Latches each instruction, decodes it, and steps the datapath through FETCH/DECODE/EXEC/MEM/WB.
- Drives the register-file control strobes (regdst, regwrite), memory strobes, PC update and a retire counter.
- Handles a ready-based handshake with instruction and data memory, with a timeout guard on data memory.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting for mem_ready in MEM before error abort; legal range 1..255.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = keep executing, 0 = stop at next instruction boundary.
- instr  in  8  instruction word from instruction memory: [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd/imm.
- instr_valid  in  1  instr is valid this cycle.
- mem_ready  in  1  data memory has completed the current read/write.
- instr_req  out  1  request instruction at current PC.
- ir  out  8  latched instruction; feeds the register-file read/destination select fields.
- regdst  out  1  1 = write rd, 0 = write rt.
- regwrite  out  1  register-file write enable.
- alusrc  out  1  1 = ALU B operand is zero-extended imm (ir[1:0]).
- memread  out  1  data memory read strobe.
- memwrite  out  1  data memory write strobe.
- memtoreg  out  1  1 = write-back data comes from memory.
- pc_en  out  1  PC update strobe, exactly one cycle per retired instruction.
- pc_jump  out  1  with pc_en: load jump target instead of PC+1.
- busy  out  1  state != IDLE.
- err  out  1  sticky data-memory timeout flag.
- instr_count  out  8  retired-instruction counter.

Behaviour:
- Reset (RESET=0, async):
  - state=IDLE; ir=0; err=0; instr_count=0; timeout counter=0.
  - All strobes 0.
- Strobes are decoded combinationally from registered state and ir[7:6]. There are no glitch-sensitive loops.
- Opcodes:
  - 00 ADD: rd = rs + rt.
  - 01 LW: rt = mem[rs + imm].
  - 10 SW: mem[rs + imm] = rt.
  - 11 JMP.
- State transitions:
  - IDLE: instr_req=0. Go to FETCH when run=1 and err=0.
  - FETCH: instr_req=1. Stay until instr_valid=1; on that edge load ir=instr and go to DECODE.
  - DECODE: one cycle, no strobes. The register file captures its read data on this edge. Go to EXEC.
  - EXEC:
    - ADD: go to WB.
    - LW/SW: alusrc=1; clear timeout counter; go to MEM.
    - JMP: pc_en=1, pc_jump=1; retire.
  - MEM:
    - LW asserts memread=1; SW asserts memwrite=1. Alusrc=1 is held.
    - On mem_ready=1: LW goes to WB; SW asserts pc_en=1 that cycle and retires.
    - Each cycle without mem_ready increments the timeout counter. When it reaches MEM_TIMEOUT: set err=1, drop strobes, go to IDLE, no retire, no PC update.
  - WB:
    - regwrite=1 and pc_en=1 for one cycle.
    - ADD: regdst=1, memtoreg=0.
    - LW: regdst=0, memtoreg=1.
    - Retire.
- Retire means: instr_count += 1 (wraps 255 -> 0); next state is FETCH if run=1, else IDLE.
- Latency, no wait states: ADD 4 cycles, LW 5, SW 4, JMP 3 (FETCH to retire inclusive).
- run deasserted mid-instruction: the instruction completes; stop occurs only at retire.
- instr_valid or mem_ready asserted outside FETCH/MEM: ignored.
- err clears only by reset. While err=1, IDLE does not leave.
- Reset mid-instruction: immediate abort to IDLE; no partial regwrite or memwrite after reset asserts.

Optional Feature:
- Macro: CPU_CONTROL_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - In IDLE with run=0, a rising edge of step (edge-detected internally) starts exactly one instruction.
  - That instruction returns to IDLE at retire regardless of step level.
  - step is ignored while busy.
- When undefined: no step port; only run starts execution.

Decomposition:
- Shared package cpu_pkg:
  - State enum: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5 (3 bits).
  - Opcode constants: OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_JMP=2'b11.
  - Instruction field bit positions.
- One natural sub-module: cpu_control_decode, a combinational (state, opcode) -> strobe bundle. The FSM, timeout counter and retire counter stay in the top module.

Test Plan:
- Reset/idle: hold RESET=0 with run=1 -> all strobes 0, busy=0, instr_count=0. Release with run=1 -> instr_req=1 next cycle.
- ADD: instr=8'b00_01_10_11 with instr_valid on first FETCH cycle -> WB on 4th cycle with regwrite=1, regdst=1, pc_en=1; instr_count=1.
- LW with 3 wait states: instr=8'h5A -> memread=1 for 4 cycles, then WB with regwrite=1, regdst=0, memtoreg=1; total 8 cycles.
- SW timeout: instr=8'h9B, mem_ready held 0 -> after 15 MEM cycles err=1, state IDLE, no pc_en. run=1 does not restart.
- Wrap and stop: 256 JMPs (8'hC0) with run=1 -> instr_count wraps to 0, pc_jump=1 with every pc_en. Drop run during DECODE of the last one -> it retires, then IDLE.
- Single step (macro defined): run=0, step pulse -> exactly one instruction retires, busy falls. A second pulse while busy is ignored.
